// File: rtl/i2c_cond_detect.sv
// I2C bus condition detector: synchronises and glitch-filters SCL/SDA, reports START, repeated
// START, STOP, bit/byte progress, and (when I2C_TIMEOUT_EN is defined) an SCL-low timeout.
module i2c_cond_detect #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3,
    parameter int TIMEOUT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 scl,
    input  logic                 sda,
    input  logic [TIMEOUT_W-1:0] timeout_cycles,
    output logic                 start,
    output logic                 rstart,
    output logic                 stop,
    output logic                 busy,
    output logic [3:0]           bit_cnt,
    output logic                 byte_done,
    output logic                 timeout,
    output logic                 scl_f,
    output logic                 sda_f
);

    localparam int                FCNT_W    = 4;
    localparam logic [FCNT_W-1:0] FILT_LAST = FCNT_W'(FILT_LEN - 1);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t                  state, state_nx;
    logic [SYNC_STAGES-1:0]  scl_sync, sda_sync;
    logic [1:0]              line_s, line_f;
    logic [1:0][FCNT_W-1:0]  fcnt;
    logic                    scl_f_p1, sda_f_p1;
    logic                    start_cond, stop_cond, scl_rise, expire;
    logic                    start_nx, rstart_nx, stop_nx, byte_done_nx;
    logic [3:0]              bit_cnt_nx;

    // Stage 0: synchronisers, reset to the idle (released) bus level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
        end
    end

    assign line_s = {scl_sync[SYNC_STAGES-1], sda_sync[SYNC_STAGES-1]};

    // Stage 1: glitch filter; fcnt counts consecutive samples that disagree with the filtered level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_f <= 2'b11;
            fcnt   <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (line_s[i] == line_f[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == FILT_LAST) begin
                    line_f[i] <= line_s[i];
                    fcnt[i]   <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + FCNT_W'(1);
                end
            end
        end
    end

    assign scl_f = line_f[1];
    assign sda_f = line_f[0];

    // Stage 2: previous filtered levels for edge and condition detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_f_p1 <= 1'b1;
            sda_f_p1 <= 1'b1;
        end else begin
            scl_f_p1 <= scl_f;
            sda_f_p1 <= sda_f;
        end
    end

    // A simultaneous SCL change fails the "high in both cycles" test, so it never qualifies.
    assign start_cond = scl_f_p1 & scl_f & sda_f_p1 & ~sda_f;
    assign stop_cond  = scl_f_p1 & scl_f & ~sda_f_p1 & sda_f;
    assign scl_rise   = ~scl_f_p1 & scl_f;

`ifdef I2C_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] tcnt, tcnt_inc;

    function automatic logic [TIMEOUT_W-1:0] sat_inc(input logic [TIMEOUT_W-1:0] v);
        return (&v) ? v : v + TIMEOUT_W'(1);
    endfunction

    assign tcnt_inc = sat_inc(tcnt);
    assign expire   = (state == BUSY) && !scl_f && (timeout_cycles != '0) &&
                      (tcnt_inc == timeout_cycles);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tcnt <= '0;
        end else if ((state == BUSY) && !scl_f && !expire) begin
            tcnt <= tcnt_inc;
        end else begin
            tcnt <= '0;
        end
    end
`else
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = ^timeout_cycles;
    assign expire                = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_cond) state_nx = BUSY;
            BUSY:    if (stop_cond || expire) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        start_nx     = (state == IDLE) && start_cond;
        rstart_nx    = (state == BUSY) && start_cond;
        stop_nx      = (state == BUSY) && stop_cond;
        byte_done_nx = 1'b0;
        bit_cnt_nx   = bit_cnt;
        if (start_cond || expire) begin
            bit_cnt_nx = 4'd0;
        end else if ((state == BUSY) && scl_rise) begin
            if (bit_cnt == 4'd8) begin
                bit_cnt_nx   = 4'd0;
                byte_done_nx = 1'b1;
            end else begin
                bit_cnt_nx = bit_cnt + 4'd1;
            end
        end
    end

    // Stage 3: registered state and pulse outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            start     <= 1'b0;
            rstart    <= 1'b0;
            stop      <= 1'b0;
            timeout   <= 1'b0;
            byte_done <= 1'b0;
            bit_cnt   <= 4'd0;
        end else begin
            state     <= state_nx;
            busy      <= (state_nx == BUSY);
            start     <= start_nx;
            rstart    <= rstart_nx;
            stop      <= stop_nx;
            timeout   <= expire;
            byte_done <= byte_done_nx;
            bit_cnt   <= bit_cnt_nx;
        end
    end

endmodule
